// File: rtl/user_rq_rr_arbiter.sv
// Round-robin arbiter for the shared user read-request path, with a per-source cap on
// outstanding requests and a single registered output slot tagged with the source index.
module user_rq_rr_arbiter #(
    parameter int N_SRCS   = 4,
    parameter int REQ_BITS = 32,
    parameter int MAX_OUT  = 8,
    localparam int SRC_W   = $clog2(N_SRCS)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_SRCS-1:0]          s_req_valid,
    output logic [N_SRCS-1:0]          s_req_ready,
    input  logic [N_SRCS*REQ_BITS-1:0] s_req_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [REQ_BITS-1:0]        m_req_data,
    output logic [SRC_W-1:0]           m_req_src,
    input  logic                       cpl_valid,
    input  logic [SRC_W-1:0]           cpl_src,
    output logic [N_SRCS-1:0]          outst_full,
    output logic                       err_cpl
);

    localparam logic [7:0]       MAX_CNT  = 8'(MAX_OUT);
    localparam logic [SRC_W:0]   N_EXT    = (SRC_W+1)'(N_SRCS);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRCS - 1);

    logic [7:0]          cnt [N_SRCS];
    logic [SRC_W-1:0]    rr_ptr;
    logic                slot_free;
    logic [N_SRCS-1:0]   eligible;
    logic [2*N_SRCS-1:0] elig_dbl;
    logic [N_SRCS-1:0]   elig_rot;
    logic                found;
    logic [SRC_W-1:0]    offset;
    logic [SRC_W:0]      idx_sum;
    logic                grant_vld;
    logic [SRC_W-1:0]    grant_idx;
    logic [N_SRCS-1:0]   inc;
    logic [N_SRCS-1:0]   dec;
    logic                cpl_zero;
    logic                cpl_bad_src;
    logic [REQ_BITS-1:0] sel_data;

    assign slot_free = !m_req_valid || m_req_ready;

    always_comb begin
        eligible   = '0;
        outst_full = '0;
        for (int i = 0; i < N_SRCS; i++) begin
            eligible[i]   = s_req_valid[i] && (cnt[i] < MAX_CNT);
            outst_full[i] = (cnt[i] == MAX_CNT);
        end
    end

    // Rotate eligibility so bit 0 is rr_ptr, find the first set bit, then map back.
    always_comb begin
        elig_dbl = {eligible, eligible} >> rr_ptr;
        elig_rot = elig_dbl[N_SRCS-1:0];
        found    = 1'b0;
        offset   = '0;
        for (int k = 0; k < N_SRCS; k++) begin
            if (!found && elig_rot[k]) begin
                found  = 1'b1;
                offset = SRC_W'(k);
            end
        end
        idx_sum   = {1'b0, rr_ptr} + {1'b0, offset};
        grant_idx = (idx_sum >= N_EXT) ? SRC_W'(idx_sum - N_EXT) : idx_sum[SRC_W-1:0];
        grant_vld = found && slot_free && aresetn;
    end

    always_comb begin
        inc         = '0;
        dec         = '0;
        cpl_zero    = 1'b0;
        sel_data    = '0;
        s_req_ready = '0;
        for (int i = 0; i < N_SRCS; i++) begin
            inc[i]         = grant_vld && (grant_idx == SRC_W'(i));
            dec[i]         = cpl_valid && (cpl_src == SRC_W'(i));
            s_req_ready[i] = inc[i];
            if (dec[i] && !inc[i] && (cnt[i] == 8'd0))
                cpl_zero = 1'b1;
            if (grant_idx == SRC_W'(i))
                sel_data = s_req_data[i*REQ_BITS +: REQ_BITS];
        end
        cpl_bad_src = cpl_valid && ({1'b0, cpl_src} >= N_EXT);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < N_SRCS; i++)
                cnt[i] <= 8'd0;
            rr_ptr      <= '0;
            m_req_valid <= 1'b0;
            err_cpl     <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRCS; i++) begin
                if (inc[i] && !dec[i])
                    cnt[i] <= cnt[i] + 8'd1;
                else if (dec[i] && !inc[i] && (cnt[i] != 8'd0))
                    cnt[i] <= cnt[i] - 8'd1;
            end
            if (grant_vld)
                rr_ptr <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            if (slot_free)
                m_req_valid <= grant_vld;
            if (cpl_zero || cpl_bad_src)
                err_cpl <= 1'b1;
        end
    end

    // Payload only loads on a grant, so it holds while the slot is stalled.
    always_ff @(posedge aclk) begin
        if (grant_vld) begin
            m_req_data <= sel_data;
            m_req_src  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_user_rq_rr_arbiter.sv
// Directed bench for user_rq_rr_arbiter: rotation, credit cap, skip of full sources,
// output hold under backpressure, completion errors and mid-run reset.
module tb_user_rq_rr_arbiter;

    logic         aclk;
    logic         aresetn;
    logic [3:0]   s_req_valid;
    logic [3:0]   s_req_ready;
    logic [127:0] s_req_data;
    logic         m_req_valid;
    logic         m_req_ready;
    logic [31:0]  m_req_data;
    logic [1:0]   m_req_src;
    logic         cpl_valid;
    logic [1:0]   cpl_src;
    logic [3:0]   outst_full;
    logic         err_cpl;

    int n_cmp = 0;
    int n_err = 0;

    user_rq_rr_arbiter #(.N_SRCS(4), .REQ_BITS(32), .MAX_OUT(8)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_req_src   (m_req_src),
        .cpl_valid   (cpl_valid),
        .cpl_src     (cpl_src),
        .outst_full  (outst_full),
        .err_cpl     (err_cpl)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn     = 1'b0;
        s_req_valid = 4'b0000;
        s_req_data  = '0;
        m_req_ready = 1'b1;
        cpl_valid   = 1'b0;
        cpl_src     = 2'd0;
        tick();
        tick();
        #1;
        chk("rst_m_valid", 64'(m_req_valid), 64'(1'b0));
        chk("rst_s_ready", 64'(s_req_ready), 64'(4'b0000));
        chk("rst_full",    64'(outst_full),  64'(4'b0000));
        chk("rst_err",     64'(err_cpl),     64'(1'b0));

        // 1: all sources valid, completions return one cycle after issue
        aresetn     = 1'b1;
        s_req_valid = 4'b1111;
        for (int i = 0; i < 4; i++)
            s_req_data[i*32 +: 32] = 32'h100 + 32'(i);
        for (int k = 0; k < 8; k++) begin
            cpl_valid = (k > 0);
            cpl_src   = 2'((k + 3) % 4);
            #1;
            chk("t1_ready", 64'(s_req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                chk("t1_src",  64'(m_req_src),  64'((k - 1) % 4));
                chk("t1_data", 64'(m_req_data), 64'(32'h100 + 32'((k - 1) % 4)));
            end
            tick();
        end
        s_req_valid = 4'b0000;
        cpl_valid   = 1'b1;
        cpl_src     = 2'd3;
        #1;
        chk("t1_last_valid", 64'(m_req_valid), 64'(1'b1));
        chk("t1_last_src",   64'(m_req_src),   64'(2'd3));
        tick();
        cpl_valid = 1'b0;
        #1;
        chk("t1_drain_valid", 64'(m_req_valid), 64'(1'b0));
        chk("t1_no_err",      64'(err_cpl),     64'(1'b0));

        // 2: only src2, cap of 8 then one completion frees one slot
        s_req_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_ready", 64'(s_req_ready), 64'(4'b0100));
            tick();
        end
        cpl_valid = 1'b1;
        cpl_src   = 2'd2;
        #1;
        chk("t2_capped_ready", 64'(s_req_ready), 64'(4'b0000));
        chk("t2_full",         64'(outst_full),  64'(4'b0100));
        chk("t2_m_src",        64'(m_req_src),   64'(2'd2));
        tick();
        cpl_valid = 1'b0;
        #1;
        chk("t2_regrant",    64'(s_req_ready), 64'(4'b0100));
        chk("t2_not_full",   64'(outst_full),  64'(4'b0000));
        chk("t2_gap_valid",  64'(m_req_valid), 64'(1'b0));
        tick();
        #1;
        chk("t2_9th_valid", 64'(m_req_valid), 64'(1'b1));
        chk("t2_9th_src",   64'(m_req_src),   64'(2'd2));
        chk("t2_full_again", 64'(outst_full), 64'(4'b0100));

        // 3: fill src0, then src0+src1 valid: src0 skipped
        s_req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t3_fill_ready", 64'(s_req_ready), 64'(4'b0001));
            tick();
        end
        s_req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_skip_ready", 64'(s_req_ready), 64'(4'b0010));
            chk("t3_full",       64'(outst_full),  64'(4'b0101));
            tick();
        end

        // 5: src1 at cnt=3, simultaneous grant and completion leaves it at 3
        s_req_valid = 4'b0010;
        cpl_valid   = 1'b1;
        cpl_src     = 2'd1;
        #1;
        chk("t5_same_ready", 64'(s_req_ready), 64'(4'b0010));
        tick();
        cpl_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_credit_ready", 64'(s_req_ready), 64'(4'b0010));
            tick();
        end
        #1;
        chk("t5_capped_ready", 64'(s_req_ready), 64'(4'b0000));
        chk("t5_full",         64'(outst_full),  64'(4'b0111));
        s_req_valid = 4'b0000;
        cpl_valid   = 1'b1;
        cpl_src     = 2'd3;
        #1;
        chk("t5_err_before", 64'(err_cpl), 64'(1'b0));
        tick();
        cpl_valid = 1'b0;
        #1;
        chk("t5_err_set",   64'(err_cpl),    64'(1'b1));
        chk("t5_full_keep", 64'(outst_full), 64'(4'b0111));
        tick();
        tick();
        #1;
        chk("t5_err_sticky", 64'(err_cpl), 64'(1'b1));

        // 4: src3 word held under 5 cycles of backpressure
        s_req_valid              = 4'b1000;
        s_req_data[3*32 +: 32]   = 32'hABC;
        m_req_ready              = 1'b0;
        #1;
        chk("t4_load_ready", 64'(s_req_ready), 64'(4'b1000));
        tick();
        s_req_data[3*32 +: 32] = 32'hDEF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_hold_valid", 64'(m_req_valid), 64'(1'b1));
            chk("t4_hold_data",  64'(m_req_data),  64'(32'hABC));
            chk("t4_hold_src",   64'(m_req_src),   64'(2'd3));
            chk("t4_hold_ready", 64'(s_req_ready), 64'(4'b0000));
            tick();
        end
        m_req_ready = 1'b1;
        #1;
        chk("t4_release_ready", 64'(s_req_ready), 64'(4'b1000));
        chk("t4_release_data",  64'(m_req_data),  64'(32'hABC));
        tick();
        m_req_ready = 1'b0;
        #1;
        chk("t4_next_data", 64'(m_req_data),  64'(32'hDEF));
        chk("t4_next_valid", 64'(m_req_valid), 64'(1'b1));

        // 6: reset mid-operation with a pending word and three full sources
        chk("t6_pre_full", 64'(outst_full), 64'(4'b0111));
        aresetn     = 1'b0;
        s_req_valid = 4'b1111;
        #1;
        chk("t6_rst_ready", 64'(s_req_ready), 64'(4'b0000));
        tick();
        #1;
        chk("t6_valid_dropped", 64'(m_req_valid), 64'(1'b0));
        chk("t6_full_clear",    64'(outst_full),  64'(4'b0000));
        chk("t6_err_clear",     64'(err_cpl),     64'(1'b0));
        aresetn     = 1'b1;
        m_req_ready = 1'b1;
        #1;
        chk("t6_first_grant", 64'(s_req_ready), 64'(4'b0001));
        tick();
        #1;
        chk("t6_first_src",   64'(m_req_src),   64'(2'd0));
        chk("t6_first_valid", 64'(m_req_valid), 64'(1'b1));
        chk("t6_second_grant", 64'(s_req_ready), 64'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
